i2c_reg_sequencer: RTL

Command-level front end that sits directly upstream of the I2C byte master and drives its enable/mode/slave_addr/data/stop inputs. It turns one register access into two single-byte master transactions. A write is the register pointer followed by the data byte. A read is the register pointer followed by a one-byte read. The block also handles the busy handshake, bus-free gaps, retry on NACK and a stuck-master timeout, then returns one response per command.

---
 rtl/i2c_reg_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_sequencer.sv
// Register-access sequencer in front of a single-byte I2C master: splits each
// command into pointer + data/read transactions with gap, retry and timeout.
module i2c_reg_sequencer #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned MAX_RETRY  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_error,
    output logic       rsp_timeout,
    output logic [3:0] rsp_retries,
    output logic       m_enable,
    output logic       m_mode,
    output logic [6:0] m_slave_addr,
    output logic [7:0] m_data,
    output logic       m_stop,
    input  logic       m_busy,
    input  logic       m_error,
    input  logic [7:0] m_recv_buf
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
    localparam logic [7:0]    GLIM = 8'(GAP_CYCLES - 1);
    localparam logic [3:0]    RLIM = 4'(MAX_RETRY);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;

    logic [2:0]    r_state;
    logic          r_rw;
    logic [7:0]    r_reg;
    logic [7:0]    r_wdata;
    logic          r_phase;
    logic [3:0]    r_retries;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_gcnt;

    logic          r_rsp_valid;
    logic [7:0]    r_rsp_rdata;
    logic          r_rsp_error;
    logic          r_rsp_timeout;
    logic [3:0]    r_rsp_retries;

    logic          r_m_enable;
    logic          r_m_mode;
    logic [6:0]    r_m_addr;
    logic [7:0]    r_m_data;

    logic          w_tmo;

    // Only the three wait states are guarded by the timeout counter.
    assign w_tmo = (r_tcnt == TLIM) &&
                   ((r_state == S_ISSUE) || (r_state == S_WAIT_BUSY) ||
                    (r_state == S_WAIT_DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rw          <= 1'b0;
            r_reg         <= '0;
            r_wdata       <= '0;
            r_phase       <= 1'b0;
            r_retries     <= '0;
            r_tcnt        <= '0;
            r_gcnt        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_retries <= '0;
            r_m_enable    <= 1'b0;
            r_m_mode      <= 1'b0;
            r_m_addr      <= '0;
            r_m_data      <= '0;
        end else begin
            r_m_enable  <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_rw      <= cmd_rw;
                        r_reg     <= cmd_reg;
                        r_wdata   <= cmd_wdata;
                        r_phase   <= 1'b0;
                        r_retries <= '0;
                        r_tcnt    <= '0;
                        r_m_mode  <= 1'b0;
                        r_m_addr  <= cmd_dev;
                        r_m_data  <= cmd_reg;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_tmo) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_error   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_retries <= r_retries;
                        r_state       <= S_RESP;
                    end else if (m_busy) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end else begin
                        r_m_enable <= 1'b1;
                        r_tcnt     <= '0;
                        r_state    <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (w_tmo) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_error   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_retries <= r_retries;
                        r_state       <= S_RESP;
                    end else if (m_busy) begin
                        r_tcnt  <= '0;
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_tmo) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_error   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_retries <= r_retries;
                        r_state       <= S_RESP;
                    end else if (!m_busy) begin
                        r_tcnt <= '0;
                        r_gcnt <= '0;
                        if (m_error) begin
                            if (r_retries >= RLIM) begin
                                r_rsp_valid   <= 1'b1;
                                r_rsp_rdata   <= '0;
                                r_rsp_error   <= 1'b1;
                                r_rsp_timeout <= 1'b0;
                                r_rsp_retries <= r_retries;
                                r_state       <= S_RESP;
                            end else begin
                                // A failed transaction restarts the whole command from the pointer write.
                                r_retries <= r_retries + 1'b1;
                                r_phase   <= 1'b0;
                                r_m_mode  <= 1'b0;
                                r_m_data  <= r_reg;
                                r_state   <= S_GAP;
                            end
                        end else if (!r_phase) begin
                            r_phase  <= 1'b1;
                            r_m_mode <= r_rw;
                            r_m_data <= r_rw ? 8'h00 : r_wdata;
                            r_state  <= S_GAP;
                        end else begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp_rdata   <= r_rw ? m_recv_buf : 8'h00;
                            r_rsp_error   <= 1'b0;
                            r_rsp_timeout <= 1'b0;
                            r_rsp_retries <= r_retries;
                            r_state       <= S_RESP;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gcnt == GLIM) begin
                        r_tcnt  <= '0;
                        r_state <= S_ISSUE;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = (r_state == S_IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_error    = r_rsp_error;
    assign rsp_timeout  = r_rsp_timeout;
    assign rsp_retries  = r_rsp_retries;
    assign m_enable     = r_m_enable;
    assign m_mode       = r_m_mode;
    assign m_slave_addr = r_m_addr;
    assign m_data       = r_m_data;
    assign m_stop       = 1'b1;

endmodule
